// File: rtl/simple_bus.sv
// Single-cycle address-decoded interconnect: fixed-priority host arbitration, base/mask device decode,
// response routed back one cycle later. Define BUS_DECODE_ERR_EN to flag unmapped accesses with err=1.
module simple_bus #(
    parameter int NrDevices    = 1,
    parameter int NrHosts      = 1,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i    [NrHosts],
    output logic                      host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
    input  logic                      host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
    output logic                      host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
    output logic                      host_err_o    [NrHosts],

    output logic                      device_req_o    [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
    output logic                      device_we_o     [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
    input  logic                      device_rvalid_i [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
    input  logic                      device_err_i    [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
    localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int BeW      = DataWidth / 8;

`ifdef BUS_DECODE_ERR_EN
    localparam logic DecodeErr = 1'b1;
`else
    localparam logic DecodeErr = 1'b0;
`endif

    logic                    w_host_any;
    logic [HostIdxW-1:0]     w_host_idx;
    logic [AddressWidth-1:0] w_addr;
    logic                    w_we;
    logic [BeW-1:0]          w_be;
    logic [DataWidth-1:0]    w_wdata;
    logic                    w_dev_hit;
    logic [DevIdxW-1:0]      w_dev_idx;

    logic                    r_vld_p1;
    logic                    r_miss_p1;
    logic [HostIdxW-1:0]     r_host_idx_p1;
    logic [DevIdxW-1:0]      r_dev_idx_p1;

    logic                    w_rsp_rvalid;
    logic [DataWidth-1:0]    w_rsp_rdata;
    logic                    w_rsp_err;

    // ---- stage p0: arbitration, decode and request forwarding (combinational) ----
    // Descending scan: the last hit written is the lowest requesting index.
    always_comb begin
        w_host_any = 1'b0;
        w_host_idx = '0;
        for (int h = NrHosts - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                w_host_any = 1'b1;
                w_host_idx = HostIdxW'(h);
            end
        end
    end

    always_comb begin
        w_addr  = '0;
        w_we    = 1'b0;
        w_be    = '0;
        w_wdata = '0;
        for (int h = 0; h < NrHosts; h++) begin
            if (w_host_idx == HostIdxW'(h)) begin
                w_addr  = host_addr_i[h];
                w_we    = host_we_i[h];
                w_be    = host_be_i[h];
                w_wdata = host_wdata_i[h];
            end
        end
    end

    // Overlapping windows resolve to the lower device index.
    always_comb begin
        w_dev_hit = 1'b0;
        w_dev_idx = '0;
        for (int d = NrDevices - 1; d >= 0; d--) begin
            if ((w_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                w_dev_hit = 1'b1;
                w_dev_idx = DevIdxW'(d);
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = w_host_any && (w_host_idx == HostIdxW'(h));
        end
    end

    always_comb begin
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = w_host_any && w_dev_hit && (w_dev_idx == DevIdxW'(d));
            device_addr_o[d]  = w_addr;
            device_we_o[d]    = w_we;
            device_be_o[d]    = w_be;
            device_wdata_o[d] = w_wdata;
        end
    end

    // ---- stage p1: response-routing registers ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_p1      <= 1'b0;
            r_miss_p1     <= 1'b0;
            r_host_idx_p1 <= '0;
            r_dev_idx_p1  <= '0;
        end else begin
            r_vld_p1 <= w_host_any;
            if (w_host_any) begin
                r_miss_p1     <= !w_dev_hit;
                r_host_idx_p1 <= w_host_idx;
                r_dev_idx_p1  <= w_dev_idx;
            end
        end
    end

    // A decode miss completes on its own; otherwise the selected device answers.
    always_comb begin
        w_rsp_rvalid = 1'b0;
        w_rsp_rdata  = '0;
        w_rsp_err    = 1'b0;
        if (r_miss_p1) begin
            w_rsp_rvalid = 1'b1;
            w_rsp_err    = DecodeErr;
        end else begin
            for (int d = 0; d < NrDevices; d++) begin
                if (r_dev_idx_p1 == DevIdxW'(d)) begin
                    w_rsp_rvalid = device_rvalid_i[d];
                    w_rsp_rdata  = device_rdata_i[d];
                    w_rsp_err    = device_err_i[d];
                end
            end
        end
    end

    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            if (r_vld_p1 && (r_host_idx_p1 == HostIdxW'(h))) begin
                host_rvalid_o[h] = w_rsp_rvalid;
                host_rdata_o[h]  = w_rsp_rdata;
                host_err_o[h]    = w_rsp_err;
            end else begin
                host_rvalid_o[h] = 1'b0;
                host_rdata_o[h]  = '0;
                host_err_o[h]    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_simple_bus.sv
// Bench for simple_bus with two hosts and four devices (RAM, SimCtrl, Timer, Posit).
module tb_simple_bus;

    localparam int NH = 2;
    localparam int ND = 4;
    localparam int DW = 32;
    localparam int AW = 32;

`ifdef BUS_DECODE_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            host_req_i    [NH];
    logic            host_gnt_o    [NH];
    logic [AW-1:0]   host_addr_i   [NH];
    logic            host_we_i     [NH];
    logic [DW/8-1:0] host_be_i     [NH];
    logic [DW-1:0]   host_wdata_i  [NH];
    logic            host_rvalid_o [NH];
    logic [DW-1:0]   host_rdata_o  [NH];
    logic            host_err_o    [NH];
    logic            device_req_o    [ND];
    logic [AW-1:0]   device_addr_o   [ND];
    logic            device_we_o     [ND];
    logic [DW/8-1:0] device_be_o     [ND];
    logic [DW-1:0]   device_wdata_o  [ND];
    logic            device_rvalid_i [ND];
    logic [DW-1:0]   device_rdata_i  [ND];
    logic            device_err_i    [ND];
    logic [AW-1:0]   cfg_base [ND];
    logic [AW-1:0]   cfg_mask [ND];

    simple_bus #(.NrDevices(ND), .NrHosts(NH), .DataWidth(DW), .AddressWidth(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o), .host_addr_i(host_addr_i),
        .host_we_i(host_we_i), .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
        .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
        .device_err_i(device_err_i),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    always #5 clk = ~clk;

    // Device model: answers exactly one cycle after req; rdata is always driven, Posit flags err.
    localparam logic [ND-1:0] DEV_ERR = 4'b1000;
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            device_rvalid_i[d] <= device_req_o[d];
            device_err_i[d]    <= device_req_o[d] & DEV_ERR[d];
        end
    end

    typedef struct {
        logic [1:0]  req;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  exp_gnt;
        logic [3:0]  exp_dreq;
        logic        exp_host;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        valid;
        logic        host;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic [1:0] req, logic [31:0] a0, logic [31:0] a1, logic we,
                                logic [3:0] be, logic [31:0] wd, logic [1:0] g, logic [3:0] dr,
                                logic host, logic [31:0] rd, logic err);
        vec_t v;
        v = '{req, a0, a1, we, be, wd, g, dr, host, rd, err};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        exp_t e;
        logic ev;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{1'b0, 1'b0, 32'h0, 1'b0};
        for (int h = 0; h < NH; h++) begin
            ev = e.valid && (int'(e.host) == h);
            chk($sformatf("%s h%0d rvalid", tag, h), 32'(host_rvalid_o[h]), 32'(ev));
            chk($sformatf("%s h%0d rdata", tag, h), host_rdata_o[h], ev ? e.rdata : 32'h0);
            chk($sformatf("%s h%0d err", tag, h), 32'(host_err_o[h]), 32'(ev & e.err));
        end
    endtask

    // Called at posedge+1; checks the previous response and this cycle's request path.
    task automatic step(input vec_t v, input string tag);
        logic [31:0] ea;
        logic        ew;
        logic [3:0]  eb;
        logic [31:0] ed;
        host_req_i[0]   = v.req[0];   host_req_i[1]   = v.req[1];
        host_addr_i[0]  = v.addr0;    host_addr_i[1]  = v.addr1;
        host_we_i[0]    = v.we;       host_we_i[1]    = ~v.we;
        host_be_i[0]    = v.be;       host_be_i[1]    = ~v.be;
        host_wdata_i[0] = v.wdata;    host_wdata_i[1] = ~v.wdata;
        #3;
        check_resp(tag);
        for (int h = 0; h < NH; h++)
            chk($sformatf("%s gnt%0d", tag, h), 32'(host_gnt_o[h]), 32'(v.exp_gnt[h]));
        for (int d = 0; d < ND; d++)
            chk($sformatf("%s dreq%0d", tag, d), 32'(device_req_o[d]), 32'(v.exp_dreq[d]));
        if (v.exp_gnt != 2'b00) begin
            ea = v.exp_host ? v.addr1  : v.addr0;
            ew = v.exp_host ? ~v.we    : v.we;
            eb = v.exp_host ? ~v.be    : v.be;
            ed = v.exp_host ? ~v.wdata : v.wdata;
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("%s d%0d addr", tag, d), device_addr_o[d], ea);
                chk($sformatf("%s d%0d we", tag, d), 32'(device_we_o[d]), 32'(ew));
                chk($sformatf("%s d%0d be", tag, d), 32'(device_be_o[d]), 32'(eb));
                chk($sformatf("%s d%0d wdata", tag, d), device_wdata_o[d], ed);
            end
        end
        sb.push_back('{v.exp_gnt != 2'b00, v.exp_host, v.exp_rdata, v.exp_err});
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int h = 0; h < NH; h++) begin
            chk($sformatf("%s h%0d rvalid", tag, h), 32'(host_rvalid_o[h]), 32'h0);
            chk($sformatf("%s h%0d rdata", tag, h), host_rdata_o[h], 32'h0);
            chk($sformatf("%s h%0d err", tag, h), 32'(host_err_o[h]), 32'h0);
        end
    endtask

    localparam int NV = 12;
    vec_t vecs [NV];
    vec_t idle;

    initial begin
        rst_n = 1'b0;
        cfg_base = '{32'h0010_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        cfg_mask = '{32'hFFF0_0000, 32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFFF_FC00};
        device_rdata_i = '{32'hDEAD_BEEF, 32'h5151_0001, 32'h7177_0002, 32'h9055_0003};
        for (int h = 0; h < NH; h++) begin
            host_req_i[h] = 1'b0; host_addr_i[h] = '0; host_we_i[h] = 1'b0;
            host_be_i[h] = '0; host_wdata_i[h] = '0;
        end

        idle    = mk(2'b00, 0, 0, 0, 4'h0, 0, 2'b00, 4'b0000, 0, 0, 0);
        vecs[0]  = mk(2'b01, 32'h0010_0010, 0, 0, 4'hF, 0, 2'b01, 4'b0001, 0, 32'hDEAD_BEEF, 0);
        vecs[1]  = mk(2'b01, 32'h0003_0004, 0, 1, 4'hF, 32'h1234_5678, 2'b01, 4'b0100, 0, 32'h7177_0002, 0);
        vecs[2]  = mk(2'b01, 32'h0005_0000, 0, 0, 4'hF, 0, 2'b01, 4'b0000, 0, 32'h0, ERR_EXP);
        vecs[3]  = mk(2'b01, 32'h0010_0000, 0, 0, 4'h3, 0, 2'b01, 4'b0001, 0, 32'hDEAD_BEEF, 0);
        vecs[4]  = mk(2'b01, 32'h0004_0000, 0, 0, 4'hF, 0, 2'b01, 4'b1000, 0, 32'h9055_0003, 1);
        vecs[5]  = mk(2'b11, 32'h0002_0008, 32'h0003_0000, 1, 4'h5, 32'hA5A5_A5A5, 2'b01, 4'b0010, 0, 32'h5151_0001, 0);
        vecs[6]  = mk(2'b10, 0, 32'h0003_0000, 1, 4'h5, 32'hA5A5_A5A5, 2'b10, 4'b0100, 1, 32'h7177_0002, 0);
        vecs[7]  = idle;
        vecs[8]  = mk(2'b10, 0, 32'h0000_0123, 0, 4'hF, 0, 2'b10, 4'b0000, 1, 32'h0, ERR_EXP);
        vecs[9]  = mk(2'b01, 32'h001F_FFFC, 0, 0, 4'hF, 0, 2'b01, 4'b0001, 0, 32'hDEAD_BEEF, 0);
        vecs[10] = mk(2'b01, 32'h0002_0400, 0, 0, 4'hF, 0, 2'b01, 4'b0000, 0, 32'h0, ERR_EXP);
        vecs[11] = mk(2'b11, 32'h0000_03FC, 32'h0004_0010, 0, 4'hF, 0, 2'b01, 4'b0000, 0, 32'h0, ERR_EXP);

        // Reset state, during reset and in the first cycle after release.
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        for (int h = 0; h < NH; h++)
            chk($sformatf("reset gnt%0d", h), 32'(host_gnt_o[h]), 32'h0);
        rst_n = 1'b1;
        #3;
        check_idle_outputs("post-release");
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) step(vecs[i], $sformatf("v%0d", i));
        step(idle, "drain");

        // Overlapping windows: Posit temporarily shadows RAM, lower index must win.
        cfg_base[3] = 32'h0010_0000;
        cfg_mask[3] = 32'hFFF0_0000;
        step(mk(2'b01, 32'h0010_0020, 0, 0, 4'hF, 0, 2'b01, 4'b0001, 0, 32'hDEAD_BEEF, 0), "ovl");
        cfg_base[3] = 32'h0004_0000;
        cfg_mask[3] = 32'hFFFF_FC00;
        step(idle, "ovl-drain");

        // Reset asserted while a Timer response is pending.
        host_req_i[0] = 1'b1; host_addr_i[0] = 32'h0003_0000;
        host_req_i[1] = 1'b0;
        #3;
        @(posedge clk);
        #1;
        chk("rst-pend rvalid before", 32'(host_rvalid_o[0]), 32'h1);
        rst_n = 1'b0;
        host_req_i[0] = 1'b0;
        #1;
        check_idle_outputs("rst-pend assert");
        @(posedge clk);
        #1;
        check_idle_outputs("rst-pend held");
        rst_n = 1'b1;
        #3;
        check_idle_outputs("rst-pend release");
        @(posedge clk);
        #1;
        check_idle_outputs("rst-pend idle");
        sb.delete();

        step(vecs[4], "post-rst");
        step(idle, "post-rst-drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/simple_bus.md
# simple_bus

Single-cycle, address-decoded interconnect connecting NrHosts bus hosts (e.g. the core data port) to NrDevices memory-mapped devices (RAM, simulator control, timer, posit coprocessor). It arbitrates host requests, routes the winning request to the device whose base/mask window matches the address, and returns that device's response to the originating host one cycle later. It supports one outstanding transaction per cycle and keeps no buffering beyond the response-routing registers.

## Interface
- NrDevices, 1: number of device ports.
- NrHosts, 1: number of host ports.
- DataWidth, 32: data bus width.
- AddressWidth, 32: address bus width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_req_i  in  1 [NrHosts]  request.
- host_gnt_o  out  1 [NrHosts]  grant, same cycle as the request.
- host_addr_i  in  AddressWidth [NrHosts]  byte address.
- host_we_i  in  1 [NrHosts]  write enable.
- host_be_i  in  DataWidth/8 [NrHosts]  byte enables.
- host_wdata_i  in  DataWidth [NrHosts]  write data.
- host_rvalid_o  out  1 [NrHosts]  response valid.
- host_rdata_o  out  DataWidth [NrHosts]  read data.
- host_err_o  out  1 [NrHosts]  response error.
- device_req_o  out  1 [NrDevices]  request to the decoded device.
- device_addr_o, device_we_o, device_be_o, device_wdata_o  out  (same widths as host) [NrDevices]  forwarded request fields.
- device_rvalid_i, device_rdata_i, device_err_i  in  1/DataWidth/1 [NrDevices]  device response.
- cfg_device_addr_base  in  AddressWidth [NrDevices]  window base.
- cfg_device_addr_mask  in  AddressWidth [NrDevices]  window mask; the device matches when (addr & mask) == base.

## Operation
- Arbitration is combinational with fixed priority: the lowest-index requesting host wins. Only the winner sees host_gnt_o=1; all other hosts see 0 and must hold their requests.
- Decode: the winner's address is compared against every device window. The lowest-index matching device is selected, so overlapping windows resolve to the lower index.
- device_req_o[sel] = 1 only for the selected device and only while a winning request exists. All other device_req_o are 0.
- addr/we/be/wdata from the winner are driven to every device port. Only the req line qualifies the transfer.
- On grant, the winning host index, the selected device index and a decode-miss flag are registered.
- Response routing is combinational from the registered indices: host_rvalid_o[h_resp] = device_rvalid_i[d_resp], and host_rdata_o/host_err_o are taken from the same device. All other hosts see rvalid=0, rdata=0, err=0.
- Devices must assert rvalid exactly in the cycle after their req. The bus does not track longer latencies.
- Unmapped address (no window matches): with the error feature enabled, the access is still granted, no device_req is raised, and the next cycle the host gets rvalid=1, err=1, rdata=0.

## Timing
- Request → grant: 0 cycles (combinational).
- Grant → rvalid at the host: 1 cycle.
- Back-to-back transactions are allowed every cycle. The response for request N overlaps the grant for request N+1.
- Reset clears the response registers: host_rvalid_o=0, host_err_o=0 and host_rdata_o=0 while rst_ni=0 and in the first cycle after release.
- If reset is asserted mid-transaction, the pending response is dropped and is not delivered.
- Simultaneous host requests: the lower index wins. The loser retries and is granted in a later cycle with no starvation guarantee.

## Configuration
- BUS_DECODE_ERR_EN defined: unmapped accesses return rvalid=1, err=1, rdata=0 one cycle after grant.
- BUS_DECODE_ERR_EN undefined: unmapped accesses are granted, then complete silently with rvalid=1, err=0, rdata=0. host_err_o reflects only device_err_i.

## Test plan
- Config RAM 0x100000/~0xFFFFF, SimCtrl 0x20000/~0x3FF, Timer 0x30000/~0x3FF, Posit 0x40000/~0x3FF. Host 0 reads 0x100010 → gnt same cycle; device_req[0]=1 only; next cycle rvalid=1 with RAM rdata (e.g. 0xDEADBEEF), err=0.
- Write 0x30004 with wdata 0x12345678, be 0xF → device_req[2]=1, we=1, be/wdata forwarded; next cycle rvalid=1.
- Read 0x50000 (unmapped) with BUS_DECODE_ERR_EN → no device_req; next cycle rvalid=1, err=1, rdata=0. Without the macro → rvalid=1, err=0.
- Back-to-back reads 0x100000 then 0x40000 on consecutive cycles → responses delivered on consecutive cycles, each from the correct device.
- NrHosts=2, both request in the same cycle → host 0 granted, host 1 gnt=0; host 1 granted the following cycle.
- Assert rst_ni low while a response is pending → host_rvalid_o=0 immediately and stays 0 after release until a new grant.
